// File: rtl/crc_controller_pkg.sv
// crc_controller_pkg: shared types and constants for the CRC controller slice.
// Provides the register select decode, the FSM state type, status/control bit
// positions and the default CRC-32 polynomial and seed.
package crc_controller_pkg;
    localparam int WORD_SIZE = 32;

    typedef enum logic [2:0] {
        REG_NONE,
        CRC_CONTROL,
        CRC_INPUT,
        CRC_STATUS,
        CRC_OUTPUT
    } regsel_t;

    typedef enum logic {IDLE, SHIFT} crc_state_t;

    localparam int CRC_STAT_BUSY = 0;
    localparam int CRC_STAT_DONE = 1;
    localparam int CRC_STAT_OVF  = 2;
    localparam int CRC_STAT_EN   = 3;

    localparam int CRC_CTRL_INIT = 0;
    localparam int CRC_CTRL_EN   = 1;

    localparam logic [31:0] CRC32_POLY_DEFAULT = 32'h04C11DB7;
    localparam logic [31:0] CRC32_SEED_DEFAULT = 32'hFFFFFFFF;
endpackage

// File: rtl/crc_controller_lfsr_step.sv
// crc_lfsr_step: combinational N-bit MSB-first CRC LFSR advance.
// Ports: crc (current register), data_msbs (next N data bits, MSB first),
//        crc_next (register after consuming those N bits).
module crc_lfsr_step #(
    parameter logic [31:0] POLY = 32'h04C11DB7,
    parameter int          N    = 1
) (
    input  logic [31:0]  crc,
    input  logic [N-1:0] data_msbs,
    output logic [31:0]  crc_next
);
    logic [31:0] c;

    always_comb begin
        c = crc;
        for (int i = N - 1; i >= 0; i--)
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data_msbs[i]) ? POLY : 32'h0);
        crc_next = c;
    end
endmodule

// File: rtl/crc_controller.sv
// crc_controller: sequences the CRC engine from decoded APB register writes.
// Ports: CLK, nRST (async active-low), write_enable/register_select/write_data
//        from the APB slave decode; crc_status, crc_result and busy toward the
//        read-data mux.
module crc_controller
    import crc_controller_pkg::*;
#(
    parameter logic [31:0] POLY           = CRC32_POLY_DEFAULT,
    parameter logic [31:0] SEED           = CRC32_SEED_DEFAULT,
    parameter int          BITS_PER_CYCLE = 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 write_enable,
    input  regsel_t              register_select,
    input  logic [WORD_SIZE-1:0] write_data,
    output logic [31:0]          crc_status,
    output logic [31:0]          crc_result,
    output logic                 busy
);
    localparam logic [4:0] LAST = 5'(32 / BITS_PER_CYCLE - 1);

    crc_state_t  state, state_n;
    logic [31:0] crc_reg, crc_n, data_reg, data_n, crc_step;
    logic [4:0]  count, count_n;
    logic        enable, enable_n, done, done_n, overflow, overflow_n;

    crc_lfsr_step #(.POLY(POLY), .N(BITS_PER_CYCLE)) u_step (
        .crc       (crc_reg),
        .data_msbs (data_reg[31 -: BITS_PER_CYCLE]),
        .crc_next  (crc_step)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            crc_reg  <= SEED;
            data_reg <= '0;
            count    <= '0;
            enable   <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            crc_reg  <= crc_n;
            data_reg <= data_n;
            count    <= count_n;
            enable   <= enable_n;
            done     <= done_n;
            overflow <= overflow_n;
        end
    end

    // Later assignments win: an init write overrides the shift in progress.
    always_comb begin
        state_n    = state;
        crc_n      = crc_reg;
        data_n     = data_reg;
        count_n    = count;
        enable_n   = enable;
        done_n     = done;
        overflow_n = overflow;
        if (state == SHIFT) begin
            crc_n   = crc_step;
            data_n  = data_reg << BITS_PER_CYCLE;
            count_n = (count == LAST) ? 5'd0 : 5'(count + 5'd1);
            if (count == LAST) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
        if (write_enable && register_select == CRC_CONTROL) begin
            enable_n = write_data[CRC_CTRL_EN];
            if (write_data[CRC_CTRL_INIT]) begin
                crc_n      = SEED;
                done_n     = 1'b0;
                overflow_n = 1'b0;
                state_n    = IDLE;
                count_n    = '0;
            end
        end
        // A word arriving while shifting (even on the last shift) is dropped.
        if (write_enable && register_select == CRC_INPUT) begin
            if (state == SHIFT)
                overflow_n = 1'b1;
            else if (enable) begin
                data_n  = write_data;
                count_n = '0;
                done_n  = 1'b0;
                state_n = SHIFT;
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign crc_result = crc_reg;

    always_comb begin
        crc_status                = '0;
        crc_status[CRC_STAT_BUSY] = busy;
        crc_status[CRC_STAT_DONE] = done;
        crc_status[CRC_STAT_OVF]  = overflow;
        crc_status[CRC_STAT_EN]   = enable;
    end
endmodule

// File: tb/tb_crc_controller.sv
// tb_crc_controller: scoreboard bench for crc_controller against a polynomial-division model.
module tb_crc_controller;
    import crc_controller_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        write_enable = 1'b0;
    regsel_t     register_select = REG_NONE;
    logic [31:0] write_data = '0;
    logic [31:0] crc_status, crc_result, status0, result0, status8, result8;
    logic        busy, busy0, busy8;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;

    crc_controller dut (
        .CLK(CLK), .nRST(nRST), .write_enable(write_enable),
        .register_select(register_select), .write_data(write_data),
        .crc_status(crc_status), .crc_result(crc_result), .busy(busy)
    );

    crc_controller #(.SEED(32'h0), .BITS_PER_CYCLE(1)) dut0 (
        .CLK(CLK), .nRST(nRST), .write_enable(write_enable),
        .register_select(register_select), .write_data(write_data),
        .crc_status(status0), .crc_result(result0), .busy(busy0)
    );

    crc_controller #(.SEED(32'h0), .BITS_PER_CYCLE(8)) dut8 (
        .CLK(CLK), .nRST(nRST), .write_enable(write_enable),
        .register_select(register_select), .write_data(write_data),
        .crc_status(status8), .crc_result(result8), .busy(busy8)
    );

    // One CRC-32 word step = ((seed ^ data) * x^32) mod G(x), by long division.
    function automatic logic [31:0] crc_model(input logic [31:0] s, input logic [31:0] d);
        logic [63:0] v;
        v = {s ^ d, 32'h0};
        for (int i = 63; i >= 32; i--)
            if (v[i]) v = v ^ (64'({1'b1, CRC32_POLY_DEFAULT}) << (i - 32));
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input regsel_t sel, input logic [31:0] d);
        write_enable    = 1'b1;
        register_select = sel;
        write_data      = d;
        @(posedge CLK);
        #1;
        write_enable    = 1'b0;
        register_select = REG_NONE;
        write_data      = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            cyc(1);
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    // Monitor: each completed word (busy falling with done set) pops one expectation.
    logic prev_busy = 1'b0;
    always @(negedge CLK) begin
        if (nRST && prev_busy && !busy && crc_status[CRC_STAT_DONE]) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got %h, expected no word", crc_result);
            end else
                check("sb_word", crc_result, sb.pop_front());
        end
        prev_busy <= nRST ? busy : 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] cur, d;
        cyc(3);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(1);
        check("rst_result", crc_result, 32'hFFFFFFFF);
        check("rst_status", crc_status, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_result_seed0", result0, 32'h0);

        // All-ones word from the all-ones seed cancels to zero.
        wr(CRC_CONTROL, 32'h3);
        wr(CRC_INPUT, 32'hFFFFFFFF);
        sb.push_back(crc_model(32'hFFFFFFFF, 32'hFFFFFFFF));
        wait_idle(n);
        check("busy_cycles_bpc1", n, 32);
        check("ones_result", crc_result, 32'h0);
        check("ones_status", crc_status, 32'hA);

        // Zero seed, word 1: result is the polynomial itself, for both widths.
        wr(CRC_CONTROL, 32'h3);
        wr(CRC_INPUT, 32'h1);
        sb.push_back(crc_model(32'hFFFFFFFF, 32'h1));
        n = 0;
        while (busy8 && n < 100) begin
            cyc(1);
            n++;
        end
        check("busy_cycles_bpc8", n, 4);
        check("seed0_bpc8", result8, 32'h04C11DB7);
        wait_idle(n);
        check("seed0_bpc1", result0, 32'h04C11DB7);

        // Overflow 10 cycles into a word; the in-flight word must be unaffected.
        wr(CRC_CONTROL, 32'h3);
        d = $urandom;
        wr(CRC_INPUT, d);
        sb.push_back(crc_model(32'hFFFFFFFF, d));
        cur = crc_model(32'hFFFFFFFF, d);
        cyc(9);
        wr(CRC_INPUT, $urandom);
        check("ovf_mid_status", crc_status, 32'hD);
        wait_idle(n);
        check("ovf_mid_done_status", crc_status, 32'hE);

        // Init clears flags; then a write on the final shift cycle still overflows.
        wr(CRC_CONTROL, 32'h3);
        check("init_status", crc_status, 32'h8);
        d = $urandom;
        wr(CRC_INPUT, d);
        sb.push_back(crc_model(32'hFFFFFFFF, d));
        cyc(31);
        check("last_shift_busy", {31'b0, busy}, 32'h1);
        wr(CRC_INPUT, $urandom);
        check("ovf_last_status", crc_status, 32'hE);

        // Abort a word in flight; then an input with enable=0 is ignored.
        wr(CRC_CONTROL, 32'h3);
        wr(CRC_INPUT, $urandom);
        cyc(4);
        wr(CRC_CONTROL, 32'h1);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_result", crc_result, 32'hFFFFFFFF);
        check("abort_status", crc_status, 32'h0);
        wr(CRC_INPUT, $urandom);
        check("disabled_busy", {31'b0, busy}, 32'h0);
        check("disabled_status", crc_status, 32'h0);

        // Random words, chained through crc_reg, with occasional init and ignored writes.
        wr(CRC_CONTROL, 32'h3);
        cur = 32'hFFFFFFFF;
        for (int k = 0; k < 200; k++) begin
            wait_idle(n);
            cyc($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                wr(CRC_CONTROL, 32'h3);
                cur = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 3) == 0)
                wr(regsel_t'($urandom_range(0, 1) == 0 ? CRC_STATUS : ($urandom_range(0, 1) == 0 ? CRC_OUTPUT : REG_NONE)), $urandom);
            d = $urandom;
            wr(CRC_INPUT, d);
            cur = crc_model(cur, d);
            sb.push_back(cur);
        end
        wait_idle(n);

        // Reset mid-word returns every output to reset values immediately.
        cyc(2);
        wr(CRC_INPUT, $urandom);
        cyc(10);
        nRST = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_status", crc_status, 32'h0);
        check("midrst_result", crc_result, 32'hFFFFFFFF);
        check("midrst_result_seed0", result0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(2);
        check("post_rst_status", crc_status, 32'h0);
        check("post_rst_result", crc_result, 32'hFFFFFFFF);
        check("sb_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
